// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: opcodes, default latencies, result tag and latency helper for alu_issue_scheduler
package alu_sched_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_ILL = 2'b11} op_e;
  localparam int ADD_LAT_DEF = 3;
  localparam int MUL_LAT_DEF = 4;
  typedef struct packed {
    logic valid;
    logic id;
    logic loc;
  } tag_t;
  function automatic int op_lat(op_e op, int add_lat, int mul_lat);
    return op == OP_MUL ? mul_lat : add_lat;
  endfunction
endpackage

// File: rtl/alu_sched_rr_arb.sv
// alu_sched_rr_arb: 2-way round-robin arbiter; after any grant priority passes to the other requester
module alu_sched_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] elig,
  output logic [1:0] grant
);
  logic ptr;
  always_comb grant = &elig ? (ptr ? 2'b10 : 2'b01) : elig;
  always_ff @(posedge clk)
    if (reset) ptr <= 1'b0;
    else if (|grant) ptr <= grant[0];
endmodule

// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler: shares one static-latency FP ALU between two requesters; ALU_SCHED_STATS_EN enables the counters
module alu_issue_scheduler
  import alu_sched_pkg::*;
#(
  parameter int ADD_LAT = ADD_LAT_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [1:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic        alu_exception,
  input  logic        alu_overflow,
  input  logic        alu_underflow,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_result,
  output logic [2:0]  resp_flags,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_conflicts
);
  localparam int MAXL = ADD_LAT > MUL_LAT ? ADD_LAT : MUL_LAT;
  logic [MAXL-1:0] r, gslot;
  logic [MAXL-1:0] slot [2];
  tag_t [MAXL-1:0] tags, tags_n;
  logic [1:0] elig, grant;
  op_e gop;
  logic [31:0] ga, gb;
  logic issue;
  // slot[i] is the one-hot result slot requester i would occupy if issued now
  always_comb
    for (int i = 0; i < 2; i++) begin
      slot[i] = MAXL'(1) << (op_lat(op_e'(req_op[2*i +: 2]), ADD_LAT, MUL_LAT) - 1);
      elig[i] = req_valid[i] && !reset && !(|(r & slot[i]));
    end
  alu_sched_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .elig  (elig),
    .grant (grant)
  );
  assign req_ready = grant;
  always_comb begin
    gop = op_e'(grant[1] ? req_op[3:2] : req_op[1:0]);
    ga = grant[1] ? req_a[63:32] : req_a[31:0];
    gb = grant[1] ? req_b[63:32] : req_b[31:0];
    gslot = grant[1] ? slot[1] : slot[0];
    issue = |grant && gop != OP_ILL;
    alu_operation = issue ? gop : OP_ADD;
    alu_operand_a = issue ? ga : '0;
    alu_operand_b = issue ? gb : '0;
  end
  // illegal ops still occupy their slot so the local error response keeps its place in order
  always_comb begin
    tags_n = tags >> $bits(tag_t);
    for (int k = 0; k < MAXL; k++)
      if (|grant && gslot[k]) tags_n[k] = '{valid: 1'b1, id: grant[1], loc: gop == OP_ILL};
  end
  always_ff @(posedge clk)
    if (reset) begin
      r <= '0;
      tags <= '0;
    end else begin
      r <= (r | (|grant ? gslot : '0)) >> 1;
      tags <= tags_n;
    end
  always_ff @(posedge clk)
    if (reset) begin
      resp_valid <= '0;
      resp_result <= '0;
      resp_flags <= '0;
    end else begin
      resp_valid <= tags[0].valid ? (tags[0].id ? 2'b10 : 2'b01) : 2'b00;
      if (tags[0].valid) begin
        resp_result <= tags[0].loc ? '0 : alu_result;
        resp_flags <= tags[0].loc ? 3'b100 : {alu_exception, alu_overflow, alu_underflow};
      end
    end
`ifdef ALU_SCHED_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      stat_issued <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_issued <= stat_issued + 32'(|grant);
      stat_conflicts <= stat_conflicts + 32'(|req_valid && !(|grant));
    end
`else
  assign stat_issued = '0;
  assign stat_conflicts = '0;
`endif
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb_alu_issue_scheduler: directed table-driven bench with a small static-latency ALU model
module tb_alu_issue_scheduler;
  localparam int ADD_LAT = 3;
  localparam int MUL_LAT = 4;
  localparam int NV = 35;
  localparam logic [31:0] F1 = 32'h3f800000, F2 = 32'h40000000, F3 = 32'h40400000,
                          F4 = 32'h40800000, F5 = 32'h40a00000, F6 = 32'h40c00000, F8 = 32'h41000000;
  typedef struct packed {
    logic [1:0]  v;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  rdy;
    logic [1:0]  rv;
    logic [31:0] res;
    logic [2:0]  fl;
  } vec_t;
  typedef struct packed {
    logic        v;
    logic [31:0] r;
    logic [2:0]  f;
  } ap_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = '0, req_ready, alu_operation, resp_valid;
  logic [3:0] req_op = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result, resp_result, stat_issued, stat_conflicts;
  logic alu_exception, alu_overflow, alu_underflow;
  logic [2:0] resp_flags;
  int errors = 0, checks = 0;
  vec_t tv [NV];
  ap_t ap [ADD_LAT];
  ap_t mp [MUL_LAT];
  logic [1:0] eop, erv;
  logic ebub;
  logic [31:0] exp_iss, exp_cnf;

  alu_issue_scheduler #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_operation(alu_operation), .alu_result(alu_result), .alu_exception(alu_exception),
    .alu_overflow(alu_overflow), .alu_underflow(alu_underflow), .resp_valid(resp_valid),
    .resp_result(resp_result), .resp_flags(resp_flags), .stat_issued(stat_issued),
    .stat_conflicts(stat_conflicts)
  );

  always #5 clk = ~clk;

  // float helpers valid for non-negative integer values below 2^24
  function automatic logic [31:0] f2i(logic [31:0] f);
    if (f[30:23] < 8'd127) return 32'd0;
    return 32'({1'b1, f[22:0]}) >> (150 - int'(f[30:23]));
  endfunction
  function automatic logic [31:0] i2f(logic [31:0] v);
    int p;
    p = 31;
    if (v == 0) return 32'd0;
    while (!v[p]) p--;
    return {1'b0, 8'(127 + p), 23'((v << (32 - p)) >> 9)};
  endfunction
  function automatic logic [31:0] fp(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] x, y;
    x = f2i(a);
    y = f2i(b);
    return op == 2'b00 ? i2f(x + y) : op == 2'b01 ? i2f(x - y) : op == 2'b10 ? i2f(x * y) : 32'd0;
  endfunction

  // ALU model: add/sub flag underflow on sub, mul flags overflow, so flag routing is observable
  always @(posedge clk) begin
    ap[0] <= '{v: alu_operation != 2'b10, r: fp(alu_operation, alu_operand_a, alu_operand_b),
               f: alu_operation == 2'b01 ? 3'b001 : 3'b000};
    for (int k = 1; k < ADD_LAT; k++) ap[k] <= ap[k-1];
    mp[0] <= '{v: alu_operation == 2'b10, r: fp(alu_operation, alu_operand_a, alu_operand_b), f: 3'b010};
    for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
  end
  assign alu_result = mp[MUL_LAT-1].v ? mp[MUL_LAT-1].r : ap[ADD_LAT-1].r;
  assign {alu_exception, alu_overflow, alu_underflow} = mp[MUL_LAT-1].v ? mp[MUL_LAT-1].f : ap[ADD_LAT-1].f;

  function automatic vec_t mk(logic [1:0] v, logic [3:0] op, logic [63:0] a, logic [63:0] b,
                              logic [1:0] rdy, logic [1:0] rv, logic [31:0] res, logic [2:0] fl);
    return '{v: v, op: op, a: a, b: b, rdy: rdy, rv: rv, res: res, fl: fl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic drive(logic [1:0] v, logic [3:0] op, logic [63:0] a, logic [63:0] b);
    req_valid = v;
    req_op = op;
    req_a = a;
    req_b = b;
  endtask

  initial begin
    for (int i = 0; i < NV; i++) tv[i] = '0;
    tv[1]  = mk(2'b01, 4'b0000, {32'd0, F1}, {32'd0, F2}, 2'b01, 2'b00, 0, 0);
    tv[5]  = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b01, F3, 3'b000);
    tv[6]  = mk(2'b11, 4'b0000, {F2, F1}, {F2, F1}, 2'b10, 2'b00, 0, 0);
    tv[7]  = mk(2'b11, 4'b0000, {F1, F1}, {F2, F1}, 2'b01, 2'b00, 0, 0);
    tv[8]  = mk(2'b11, 4'b0001, {F1, F2}, {F2, F1}, 2'b10, 2'b00, 0, 0);
    tv[9]  = mk(2'b11, 4'b0001, {F4, F2}, {F4, F1}, 2'b01, 2'b00, 0, 0);
    tv[10] = mk(2'b10, 4'b0000, {F4, 32'd0}, {F4, 32'd0}, 2'b10, 2'b10, F4, 3'b000);
    tv[11] = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b01, F2, 3'b000);
    tv[12] = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b10, F3, 3'b000);
    tv[13] = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b01, F1, 3'b001);
    tv[14] = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b10, F8, 3'b000);
    tv[15] = mk(2'b01, 4'b0010, {32'd0, F2}, {32'd0, F3}, 2'b01, 2'b00, 0, 0);
    tv[16] = mk(2'b10, 4'b0000, {F1, 32'd0}, {F1, 32'd0}, 2'b00, 2'b00, 0, 0);
    tv[17] = mk(2'b10, 4'b0000, {F1, 32'd0}, {F1, 32'd0}, 2'b10, 2'b00, 0, 0);
    tv[20] = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b01, F6, 3'b010);
    tv[21] = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b10, F2, 3'b000);
    tv[22] = mk(2'b10, 4'b1000, {F2, 32'd0}, {F2, 32'd0}, 2'b10, 2'b00, 0, 0);
    tv[23] = mk(2'b11, 4'b1000, {F1, F2}, {F3, F3}, 2'b10, 2'b00, 0, 0);
    tv[24] = mk(2'b01, 4'b0000, {32'd0, F2}, {32'd0, F3}, 2'b00, 2'b00, 0, 0);
    tv[25] = mk(2'b01, 4'b0000, {32'd0, F2}, {32'd0, F3}, 2'b01, 2'b00, 0, 0);
    tv[27] = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b10, F4, 3'b010);
    tv[28] = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b10, F3, 3'b010);
    tv[29] = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b01, F5, 3'b000);
    tv[30] = mk(2'b10, 4'b1100, {F1, 32'd0}, {F2, 32'd0}, 2'b10, 2'b00, 0, 0);
    tv[34] = mk(2'b00, 4'b0000, 0, 0, 2'b00, 2'b10, 32'd0, 3'b100);
    drive(2'b11, 4'b0000, {F1, F1}, {F1, F1});
    repeat (3) tick();
    #1;
    chk("ready in reset", req_ready, 0);
    chk("alu op in reset", alu_operation, 0);
    chk("alu a in reset", alu_operand_a, 0);
    tick();
    reset = 1'b0;
    drive(2'b00, 4'b0000, 0, 0);
    #1;
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_result", resp_result, 0);
    chk("reset resp_flags", resp_flags, 0);
    chk("reset stat_issued", stat_issued, 0);
    chk("reset stat_conflicts", stat_conflicts, 0);
    for (int i = 0; i < NV; i++) begin
      tick();
      drive(tv[i].v, tv[i].op, tv[i].a, tv[i].b);
      #1;
      eop = tv[i].rdy[1] ? tv[i].op[3:2] : tv[i].op[1:0];
      ebub = tv[i].rdy == 2'b00 || eop == 2'b11;
      chk($sformatf("row%0d ready", i), req_ready, tv[i].rdy);
      chk($sformatf("row%0d alu op", i), alu_operation, ebub ? 2'b00 : eop);
      chk($sformatf("row%0d alu a", i), alu_operand_a, ebub ? 32'd0 : (tv[i].rdy[1] ? tv[i].a[63:32] : tv[i].a[31:0]));
      chk($sformatf("row%0d alu b", i), alu_operand_b, ebub ? 32'd0 : (tv[i].rdy[1] ? tv[i].b[63:32] : tv[i].b[31:0]));
      chk($sformatf("row%0d resp_valid", i), resp_valid, tv[i].rv);
      if (tv[i].rv != 2'b00) begin
        chk($sformatf("row%0d resp_result", i), resp_result, tv[i].res);
        chk($sformatf("row%0d resp_flags", i), resp_flags, tv[i].fl);
      end
    end
    tick();
    drive(2'b00, 4'b0000, 0, 0);
    #1;
`ifdef ALU_SCHED_STATS_EN
    exp_iss = 32'd12;
    exp_cnf = 32'd2;
`else
    exp_iss = 32'd0;
    exp_cnf = 32'd0;
`endif
    chk("table stat_issued", stat_issued, exp_iss);
    chk("table stat_conflicts", stat_conflicts, exp_cnf);
    tick();
    drive(2'b01, 4'b0000, {32'd0, F1}, {32'd0, F1});
    #1 chk("flight0 ready", req_ready, 2'b01);
    tick();
    drive(2'b10, 4'b0000, {F2, 32'd0}, {F2, 32'd0});
    #1 chk("flight1 ready", req_ready, 2'b10);
    tick();
    drive(2'b01, 4'b0000, {32'd0, F1}, {32'd0, F2});
    #1 chk("flight2 ready", req_ready, 2'b01);
    tick();
    reset = 1'b1;
    drive(2'b11, 4'b0000, {F2, F1}, {F2, F1});
    #1 chk("mid reset ready", req_ready, 2'b00);
    tick();
    reset = 1'b0;
    drive(2'b00, 4'b0000, 0, 0);
    #1;
    chk("post reset resp_valid", resp_valid, 0);
    chk("post reset resp_result", resp_result, 0);
    chk("post reset resp_flags", resp_flags, 0);
    chk("post reset alu op", alu_operation, 0);
    chk("post reset stat_issued", stat_issued, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      #1 chk($sformatf("dropped resp %0d", k), resp_valid, 0);
    end
    tick();
    drive(2'b11, 4'b0000, {F2, F1}, {F2, F1});
    #1 chk("post reset pointer", req_ready, 2'b01);
    for (int k = 0; k < 100; k++) begin
      tick();
      #1;
      chk($sformatf("burst%0d ready", k), req_ready, k % 2 == 0 ? 2'b10 : 2'b01);
      erv = k < 3 ? 2'b00 : ((k - 4) % 2 == 0 ? 2'b10 : 2'b01);
      chk($sformatf("burst%0d resp_valid", k), resp_valid, erv);
      if (erv != 2'b00) chk($sformatf("burst%0d resp_result", k), resp_result, erv[1] ? F4 : F2);
    end
    tick();
    drive(2'b00, 4'b0000, 0, 0);
    #1;
`ifdef ALU_SCHED_STATS_EN
    exp_iss = 32'd101;
`else
    exp_iss = 32'd0;
`endif
    chk("burst stat_issued", stat_issued, exp_iss);
    chk("burst stat_conflicts", stat_conflicts, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_scheduler.md
# alu_issue_scheduler

Issue scheduler that shares one static-latency floating-point ALU (add/sub/mul, fixed per-op latency, no input handshake) between two requesters. Each cycle it arbitrates round-robin among valid requests, discards any candidate whose result would collide with an in-flight result on the ALU's single result bus, and drives the ALU. It tags every issued operation so that the result returns to the originating requester. Sits between the ALU and two valid/ready client ports.

## Interface
Parameters:
- ADD_LAT, 3, cycles from issue to ALU result for add/sub (ALU pipeline depth plus its output register)
- MUL_LAT, 4, cycles from issue to ALU result for multiply; MUL_LAT ≥ 1, ADD_LAT ≥ 1, either may be larger

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept
- req_op  in  4  opcode, bits [2i+1:2i] for requester i: 00 add, 01 sub, 10 mul, 11 illegal
- req_a, req_b  in  64 each  operands, bits [32i+31:32i] for requester i
- alu_operand_a, alu_operand_b  out  32 each  ALU operands
- alu_operation  out  2  ALU opcode
- alu_result  in  32  ALU result
- alu_exception, alu_overflow, alu_underflow  in  1 each  ALU flags
- resp_valid  out  2  per-requester response strobe, one cycle
- resp_result  out  32  result, shared by both requesters
- resp_flags  out  3  {exception, overflow, underflow}
- stat_issued, stat_conflicts  out  32 each  performance counters

## Operation
- Reservation vector R[MAXL-1:0], where MAXL = max(ADD_LAT, MUL_LAT). R[k] set means a result is due k+1 cycles from now. R shifts toward 0 every cycle.
- Candidate i is eligible when req_valid[i] is set and its slot is free. The slot is R[L-1], where L is the latency of the op. Illegal op uses L = ADD_LAT.
- Round-robin arbitration among eligible candidates. Pointer starts at requester 0. After any grant, priority moves to the requester not granted.
- req_ready = grant, decided combinationally in the same cycle. The request must hold stable while valid and not ready. At most one grant per cycle.
- On grant of a legal op:
  - Drive operands and opcode to the ALU.
  - Set R[L-1].
  - Push tag {valid, id, local=0} into tag pipe slot L-1.
- On grant of an illegal op:
  - Drive a bubble to the ALU.
  - Reserve the slot as above, with tag local=1.
- No grant: drive a bubble (operation 00, operands 0, no tag).
- Tag pipe slot 0 with valid=1 at cycle t means alu_result is valid at t. The response is registered at t+1:
  - resp_valid[id] = 1.
  - resp_result = alu_result and flags = ALU flags.
  - For local=1: result = 0, flags = 3'b100.
- stat_issued counts grants.
- stat_conflicts counts cycles in which some req_valid is set but no grant occurs. Both counters wrap at 2^32.

## Timing
- Reset values:
  - req_ready = 0, resp_valid = 0, resp_result = 0, resp_flags = 0.
  - ALU outputs = bubble.
  - R = 0, tag pipe empty, RR pointer = 0, counters = 0.
- Reset mid-operation drops all in-flight responses. No resp_valid appears for ops issued before reset.
- Latency from accept to resp_valid: ADD_LAT+1 for add/sub/illegal, MUL_LAT+1 for mul.
- Issue rate is one per cycle when latencies do not collide.
- Example with defaults: mul accepted at t occupies the result slot at t+4. An add at t+1 would also land at t+4, so it is held. The add issues at t+2 or later.
- If both requesters are valid and only one is eligible, that one is granted regardless of the pointer.
- Throughput is never blocked when the slot is free. No starvation: a requester held by a conflict wins the next cycle in which it is eligible and the other requester was last granted.

## Configuration
- ALU_SCHED_STATS_EN defined: counters implemented as described.
- Not defined: stat_issued and stat_conflicts are tied to 0 and no counter flops exist. All other behaviour is identical.

## Structure
- Package alu_sched_pkg holds:
  - The opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_ILL).
  - The default ADD_LAT/MUL_LAT constants.
  - The tag struct {valid, id, local}.
  - A function returning op latency.
- Sub-module alu_sched_rr_arb: 2-way round-robin arbiter with an eligibility mask in, one-hot grant out, and pointer state.

## Test plan
- Requester 0 add 1.0+2.0 at cycle 5, ALU model returns 3.0 → resp_valid[0] at cycle 9, resp_result 32'h40400000, flags 000.
- Both requesters valid each cycle with add ops → grants alternate 0,1,0,1; one response per cycle; stat_conflicts stays 0.
- Requester 0 mul at t, requester 1 add held valid from t+1 → requester 1 ready first at t+2; responses at t+5 (mul) and t+6 (add); stat_conflicts = 1.
- Requester 1 op 11 → ALU sees a bubble; resp_valid[1] after ADD_LAT+1 cycles with result 0, flags 100.
- Assert reset with three ops in flight → no resp_valid for those ops; all outputs at reset values the cycle after reset.
- Build without ALU_SCHED_STATS_EN → stat_* read 0 after 100 grants; functional responses unchanged.
